// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - word-addressed data-memory responder with wait states and CPU stall
// Optional DMEM_ADDR_ERR_EN: adds err_o and blocks accesses with nonzero bits above the array index.
module dmem_responder #(
   parameter int ADDR_W      = 10,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        memwrite,
   input  logic [3:0]  sig_write,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        resp_valid,
`ifdef DMEM_ADDR_ERR_EN
   output logic        err_o,
`endif
   output logic        stall_o
);

   localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} stateT;

   stateT             state, stateNext;
   logic [CNT_W-1:0]  waitCnt;
   logic [ADDR_W-1:0] latIdx;
   logic              latWrite;
   logic [3:0]        latMask;
   logic [31:0]       latData;
   logic              latErr;
   logic [31:0]       memArray [0:(1<<ADDR_W)-1];

   logic              accept, doOp, useLive, memWe;
   logic [ADDR_W-1:0] opIdx;
   logic              opWrite, opErr, reqErr;
   logic [3:0]        opMask;
   logic [31:0]       opData;
   logic              unusedBits;

`ifdef DMEM_ADDR_ERR_EN
   assign reqErr     = |addr[31:ADDR_W+2];
   assign unusedBits = ^addr[1:0];
   assign err_o      = (state == RESP) && latErr;
`else
   assign reqErr     = 1'b0;
   assign unusedBits = ^{addr[1:0], addr[31:ADDR_W+2]};
`endif

   always_comb begin
      stateNext = state;
      stall_o   = 1'b0;
      accept    = 1'b0;
      doOp      = 1'b0;
      case (state)
         IDLE: begin
            if (req_valid) begin
               stall_o = 1'b1;
               accept  = 1'b1;
               if (WAIT_CYCLES == 0) begin
                  stateNext = RESP;
                  doOp      = 1'b1;
               end else begin
                  stateNext = BUSY;
               end
            end
         end
         BUSY: begin
            stall_o = 1'b1;
            if (waitCnt == CNT_ONE) begin
               stateNext = RESP;
               doOp      = 1'b1;
            end
         end
         RESP:    stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   assign resp_valid = (state == RESP);

   // Zero-wait builds enter RESP on the accept edge, so the live request feeds the array directly.
   assign useLive = (state == IDLE);
   assign opIdx   = useLive ? addr[ADDR_W+1:2] : latIdx;
   assign opWrite = useLive ? memwrite         : latWrite;
   assign opMask  = useLive ? sig_write        : latMask;
   assign opData  = useLive ? wdata            : latData;
   assign opErr   = useLive ? reqErr           : latErr;
   assign memWe   = doOp && opWrite && !opErr && rst;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         waitCnt  <= '0;
         latIdx   <= '0;
         latWrite <= 1'b0;
         latMask  <= '0;
         latData  <= '0;
         latErr   <= 1'b0;
         rdata    <= '0;
      end else begin
         state <= stateNext;
         rdata <= '0;
         if (accept) begin
            latIdx   <= addr[ADDR_W+1:2];
            latWrite <= memwrite;
            latMask  <= sig_write;
            latData  <= wdata;
            latErr   <= reqErr;
            waitCnt  <= CNT_LOAD;
         end else if (state == BUSY) begin
            waitCnt <= waitCnt - CNT_ONE;
         end
         if (doOp && !opWrite && !opErr) begin
            rdata <= memArray[opIdx];
         end
      end
   end

   // The array has no reset; contents survive rst.
   always_ff @(posedge clk) begin
      if (memWe) begin
         for (int i = 0; i < 4; i++) begin
            if (opMask[i]) memArray[opIdx][8*i +: 8] <= opData[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized model-based bench for dmem_responder (2-wait and 0-wait instances)
module tb_dmem_responder;
   localparam int AW    = 10;
   localparam int DEPTH = 1 << AW;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        reqValid, memWrite, sel;
   logic [3:0]  mask;
   logic [31:0] addrIn, wdataIn;
   logic [31:0] rdataA, rdataB;
   logic        respA, respB, stallA, stallB;
`ifdef DMEM_ADDR_ERR_EN
   logic        errA, errB;
`endif

   dmem_responder #(.ADDR_W(AW), .WAIT_CYCLES(2)) dutA (
      .clk(clk), .rst(rst), .req_valid(reqValid & ~sel), .memwrite(memWrite),
      .sig_write(mask), .addr(addrIn), .wdata(wdataIn), .rdata(rdataA),
      .resp_valid(respA),
`ifdef DMEM_ADDR_ERR_EN
      .err_o(errA),
`endif
      .stall_o(stallA));

   dmem_responder #(.ADDR_W(AW), .WAIT_CYCLES(0)) dutB (
      .clk(clk), .rst(rst), .req_valid(reqValid & sel), .memwrite(memWrite),
      .sig_write(mask), .addr(addrIn), .wdata(wdataIn), .rdata(rdataB),
      .resp_valid(respB),
`ifdef DMEM_ADDR_ERR_EN
      .err_o(errB),
`endif
      .stall_o(stallB));

   logic [31:0] refMem [2][DEPTH];
   int          total = 0, bad = 0;
   logic        expStall = 0, expResp = 0, expErr = 0;
   logic [31:0] expRdata = 0;
   logic [31:0] lastRdata = 0;
   logic [31:0] curRdata;
   logic        curStall, curResp, curErr;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s sel=%0d t=%0t got=%h want=%h", name, sel, $time, act, req);
      end
   endtask

   always @(negedge clk) begin
      curRdata = sel ? rdataB : rdataA;
      curStall = sel ? stallB : stallA;
      curResp  = sel ? respB  : respA;
`ifdef DMEM_ADDR_ERR_EN
      curErr   = sel ? errB   : errA;
`else
      curErr   = 1'b0;
`endif
      check("stall_o", 32'(curStall), 32'(expStall));
      check("resp_valid", 32'(curResp), 32'(expResp));
      check("rdata", curRdata, expRdata);
`ifdef DMEM_ADDR_ERR_EN
      check("err_o", 32'(curErr), 32'(expErr));
`endif
      if (curResp) lastRdata = curRdata;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         tick();
         reqValid = 1'b0;
         memWrite = 1'($urandom);
         mask     = 4'($urandom);
         addrIn   = $urandom;
         wdataIn  = $urandom;
         expStall = 1'b0; expResp = 1'b0; expRdata = '0; expErr = 1'b0;
      end
   endtask

   // One access: stall for cycles 1..W+1, one-cycle response in cycle W+2.
   task automatic txn(input logic s, input logic we, input logic [3:0] m,
                      input logic [31:0] a, input logic [31:0] d);
      int w;
      int idx;
      logic er;
      logic [31:0] old;
      w   = s ? 0 : 2;
      idx = int'(a[AW+1:2]);
      er  = 1'b0;
`ifdef DMEM_ADDR_ERR_EN
      er  = |a[31:AW+2];
`endif
      old = refMem[s][idx];
      if (we && !er)
         for (int i = 0; i < 4; i++)
            if (m[i]) refMem[s][idx][8*i +: 8] = d[8*i +: 8];
      tick();
      sel = s; reqValid = 1'b1; memWrite = we; mask = m; addrIn = a; wdataIn = d;
      expStall = 1'b1; expResp = 1'b0; expRdata = '0; expErr = 1'b0;
      repeat (w) begin
         tick();
         memWrite = 1'($urandom); mask = 4'($urandom); addrIn = $urandom; wdataIn = $urandom;
      end
      tick();
      expStall = 1'b0; expResp = 1'b1; expRdata = (we || er) ? 32'h0 : old; expErr = er;
   endtask

   logic        rs, rw;
   logic [31:0] ra;

   initial begin
      rst = 1'b0; sel = 1'b0; reqValid = 1'b0; memWrite = 1'b0; mask = '0;
      addrIn = '0; wdataIn = '0;
      repeat (3) tick();
      rst = 1'b1;
      idle(10);

      for (int s = 0; s < 2; s++)
         for (int i = 0; i < DEPTH; i++)
            txn(1'(s), 1'b1, 4'hF, 32'(i) << 2, $urandom);
      idle(1);

      for (int s = 0; s < 2; s++) begin
         txn(1'(s), 1'b1, 4'hF, 32'h40, 32'hDEADBEEF);
         txn(1'(s), 1'b0, 4'h0, 32'h40, 32'h0);
         idle(1);
         check("full word readback", lastRdata, 32'hDEADBEEF);

         txn(1'(s), 1'b1, 4'hF, 32'h80, 32'h11223344);
         txn(1'(s), 1'b1, 4'b1010, 32'h80, 32'hAA00BB00);
         txn(1'(s), 1'b1, 4'b0000, 32'h80, 32'hFFFFFFFF);
         txn(1'(s), 1'b0, 4'h0, 32'h80, 32'h0);
         idle(1);
         check("lane merge", lastRdata, 32'hAA22BB44);

         txn(1'(s), 1'b1, 4'hF, 32'h4, 32'h0BADC0DE);
         txn(1'(s), 1'b1, 4'hF, 32'h1004, 32'h5A5A5A5A);
         txn(1'(s), 1'b0, 4'h0, 32'h4, 32'h0);
         idle(1);
`ifdef DMEM_ADDR_ERR_EN
         check("out of range write", lastRdata, 32'h0BADC0DE);
`else
         check("address wrap", lastRdata, 32'h5A5A5A5A);
`endif
         idle(2);
      end

      txn(1'b0, 1'b1, 4'hF, 32'h10, 32'hCAFEF00D);
      tick();
      sel = 1'b0; reqValid = 1'b1; memWrite = 1'b1; mask = 4'hF;
      addrIn = 32'h10; wdataIn = 32'h12345678;
      expStall = 1'b1; expResp = 1'b0; expRdata = '0;
      tick();
      rst = 1'b0; reqValid = 1'b0;
      expStall = 1'b0;
      idle(2);
      rst = 1'b1;
      idle(2);
      txn(1'b0, 1'b0, 4'h0, 32'h10, 32'h0);
      idle(1);
      check("reset drops write", lastRdata, 32'hCAFEF00D);

      for (int k = 0; k < 400; k++) begin
         rs = 1'($urandom);
         rw = 1'($urandom);
         ra = {($urandom_range(0, 3) == 0) ? 20'($urandom) : 20'h0, 10'($urandom), 2'($urandom)};
         txn(rs, rw, 4'($urandom), ra, $urandom);
         idle($urandom_range(0, 2));
      end
      idle(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
